// File: rtl/mv_bcd_converter.sv
// Converts one selected millivolt channel to four packed BCD digits using a
// sequential shift-add-3 engine with start/busy/done handshake and optional auto-retrigger.
module mv_bcd_converter #(
  parameter int unsigned AUTO_PERIOD = 0,
  parameter int unsigned BIN_W       = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] xadc_mv,
  input  logic [15:0] pwm_mv,
  input  logic [15:0] r2r_mv,
  input  logic [1:0]  sel,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        ovf
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] SAT_VAL  = BIN_W'(16'd9999);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [15:0]      bcd_out_q, bcd_out_d;
  logic             ovf_q, ovf_d;
  logic             auto_tick;
  logic [15:0]      sel_val;
  logic [15:0]      corr;

  // Free-running retrigger counter; ticks once per period at wrap.
  if (AUTO_PERIOD > 0) begin : g_auto
    localparam int unsigned AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AW-1:0] WRAP = AW'(AUTO_PERIOD - 1);
    logic [AW-1:0] auto_cnt_q;

    always_ff @(posedge clk) begin
      if (reset || auto_cnt_q == WRAP) auto_cnt_q <= '0;
      else                             auto_cnt_q <= auto_cnt_q + 1'b1;
    end

    assign auto_tick = (auto_cnt_q == WRAP);
  end else begin : g_no_auto
    assign auto_tick = 1'b0;
  end

  always_comb begin
    case (sel)
      2'd1:    sel_val = pwm_mv;
      2'd2:    sel_val = r2r_mv;
      default: sel_val = xadc_mv;
    endcase
  end

  always_comb begin
    corr = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      logic [3:0] nib;
      nib = bcd_q[4*i +: 4];
      corr[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_out_d  = bcd_out_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start || auto_tick) begin
          if (sel_val > 16'd9999) begin
            bin_d      = SAT_VAL;
            ovf_pend_d = 1'b1;
          end else begin
            bin_d      = sel_val[BIN_W-1:0];
            ovf_pend_d = 1'b0;
          end
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {corr, bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        // Results are captured on the same edge that enters DONE.
        if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          bcd_out_d = bcd_d;
          ovf_d     = ovf_pend_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_out_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_out_q  <= bcd_out_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign bcd_out = bcd_out_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mv_bcd_converter.sv
// Directed bench for mv_bcd_converter: one instance with auto-start off, one with
// AUTO_PERIOD=32; expected BCD results flow through scoreboard queues.
module tb_mv_bcd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] xadc_mv, pwm_mv, r2r_mv;
  logic [1:0]  sel;
  logic        start;
  logic        busy, done, ovf;
  logic [15:0] bcd_out;

  logic [15:0] r2r2;
  logic        start2;
  logic        busy2, done2, ovf2;
  logic [15:0] bcd_out2;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  logic [16:0] sb[$];
  logic [16:0] sb2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mv_bcd_converter u_dut (
    .clk(clk), .reset(reset), .xadc_mv(xadc_mv), .pwm_mv(pwm_mv), .r2r_mv(r2r_mv),
    .sel(sel), .start(start), .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
  );

  mv_bcd_converter #(.AUTO_PERIOD(32)) u_auto (
    .clk(clk), .reset(reset), .xadc_mv(16'd0), .pwm_mv(16'd0), .r2r_mv(r2r2),
    .sel(2'd2), .start(start2), .busy(busy2), .done(done2), .bcd_out(bcd_out2), .ovf(ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] v);
    int unsigned n;
    n = (v > 16'd9999) ? 9999 : int'(v);
    return {v > 16'd9999, 4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      logic [16:0] exp;
      done_cnt++;
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(exp[15:0]));
        chk("ovf", 32'(ovf), 32'(exp[16]));
      end
    end
  end

  task automatic convert(input logic [1:0] s, input logic [15:0] v);
    int unsigned k;
    bit seen;
    xadc_mv = 16'($urandom); pwm_mv = 16'($urandom); r2r_mv = 16'($urandom);
    case (s)
      2'd1:    pwm_mv = v;
      2'd2:    r2r_mv = v;
      default: xadc_mv = v;
    endcase
    sel = s;
    start = 1'b1;
    sb.push_back(model(v));
    @(negedge clk);
    start = 1'b0;
    xadc_mv = 16'($urandom); pwm_mv = 16'($urandom); r2r_mv = 16'($urandom);
    k = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    seen = 0;
    while (!seen && k < 40) begin
      if (done === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk("latency", k, 32'd15);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_back_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0, last, k;
    logic [15:0] vals[7];
    logic [16:0] exp;
    vals = '{16'd0, 16'd500, 16'd1000, 16'd1650, 16'd2200, 16'd2750, 16'd3300};

    reset = 1'b1; start = 1'b0; start2 = 1'b0; sel = 2'd0;
    xadc_mv = '0; pwm_mv = '0; r2r_mv = '0; r2r2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    convert(2'd0, 16'd3300);
    convert(2'd1, 16'd0);
    convert(2'd2, 16'd1289);
    convert(2'd0, 16'd9999);
    convert(2'd0, 16'd10000);
    convert(2'd0, 16'd65535);
    convert(2'd3, 16'd42);
    convert(2'd2, 16'd7);

    // Start while busy is dropped.
    d0 = done_cnt;
    sel = 2'd0; xadc_mv = 16'd1234; start = 1'b1;
    sb.push_back(model(16'd1234));
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    xadc_mv = 16'd555; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    chk("busy_start_single_done", done_cnt - d0, 32'd1);
    convert(2'd0, 16'd4321);

    // Reset in the middle of a conversion.
    sel = 2'd2; r2r_mv = 16'd2222; start = 1'b1;
    sb.push_back(model(16'd2222));
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_bcd", 32'(bcd_out), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    sb.delete();
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    convert(2'd1, 16'd808);

    // Auto-retrigger every 32 cycles with the r2r input stepping upward.
    r2r2 = vals[0];
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb2.push_back(model(vals[0]));
    last = 0;
    for (int i = 0; i < 7; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (done2 !== 1'b1 && k < 100);
      chk("auto_done_seen", 32'(done2), 32'd1);
      chk("auto_sb_has_entry", 32'(sb2.size() != 0), 32'd1);
      if (sb2.size() != 0) begin
        exp = sb2.pop_front();
        chk("auto_bcd_out", 32'(bcd_out2), 32'(exp[15:0]));
        chk("auto_ovf", 32'(ovf2), 32'(exp[16]));
      end
      if (i > 0) chk("auto_period", cyc - last, 32'd32);
      last = cyc;
      if (i + 1 < 7) begin
        r2r2 = vals[i+1];
        sb2.push_back(model(vals[i+1]));
      end
      // Start lands on the same edge as the next auto tick.
      if (i == 3) begin
        repeat (17) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
